// File: rtl/alu_seg_pkg.sv
// Shared types and display constants for the registered ALU / multiplexed seven-segment display.
package alu_seg_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      SHOW = 2'b10
   } state_e;

   // Active-low {g,f,e,d,c,b,a}: all segments off, and only g lit.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

endpackage

// File: rtl/alu_seg_scan_display_seg7_hex_decoder.sv
// Nibble to active-low seven-segment code {g,f,e,d,c,b,a}; purely combinational, no flow control.
module seg7_hex_decoder (
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/alu_seg_scan_display.sv
// Registered ALU with multiplexed seven-segment readout; result one cycle after accept.
// in_ready drops only during the single CALC cycle; operands offered then are ignored.
import alu_seg_pkg::*;

module alu_seg_scan_display #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DIGITS   = WIDTH / 4 + 1,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [1:0]        op,
   output logic [WIDTH:0]    result,
   output logic              neg,
   output logic              res_valid,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg
);

   localparam int unsigned IDX_W   = $clog2(DIGITS);
   localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
   localparam int unsigned NIB_W   = 4 * DIGITS;

   state_e             state, state_nxt;
   logic               accept, calc;
   logic [WIDTH-1:0]   a_r, b_r;
   op_e                op_r;
   logic [WIDTH:0]     alu_res;
   logic               alu_neg;
   logic [PRESC_W-1:0] presc;
   logic [IDX_W-1:0]   idx;
   logic [NIB_W-1:0]   upper;
   logic [3:0]         nib;
   logic [6:0]         dec_seg, seg_nxt;
   logic [DIGITS-1:0]  an_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b1;
      accept    = 1'b0;
      calc      = 1'b0;
      case (state)
         IDLE, SHOW: begin
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            in_ready  = 1'b0;
            calc      = 1'b1;
            state_nxt = SHOW;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r  <= '0;
         b_r  <= '0;
         op_r <= OP_ADD;
      end else if (accept) begin
         a_r  <= a;
         b_r  <= b;
         op_r <= op_e'(op);
      end
   end

   // SUB reports a magnitude plus sign so the display never needs two's complement.
   always_comb begin
      alu_res = '0;
      alu_neg = 1'b0;
      case (op_r)
         OP_ADD: alu_res = {1'b0, a_r} + {1'b0, b_r};
         OP_SUB: begin
            if (a_r >= b_r) begin
               alu_res = {1'b0, a_r - b_r};
            end else begin
               alu_res = {1'b0, b_r - a_r};
               alu_neg = 1'b1;
            end
         end
         OP_AND: alu_res = {1'b0, a_r & b_r};
         OP_OR:  alu_res = {1'b0, a_r | b_r};
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result    <= '0;
         neg       <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         res_valid <= calc;
         if (calc) begin
            result <= alu_res;
            neg    <= alu_neg;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PRESC_W'(SCAN_DIV - 1)) begin
         presc <= '0;
         idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Everything from the current nibble upward; zero means this digit is a leading zero.
   always_comb begin
      upper = NIB_W'(result) >> {idx, 2'b00};
      nib   = upper[3:0];
   end

   seg7_hex_decoder u_dec (
      .nib (nib),
      .seg (dec_seg)
   );

   always_comb begin
      an_nxt = ~(DIGITS'(1) << idx);
      if (neg && idx == IDX_W'(DIGITS - 1))
         seg_nxt = SEG_MINUS;
      else if (BLANK_LZ != 0 && idx != '0 && upper == '0)
         seg_nxt = SEG_BLANK;
      else
         seg_nxt = dec_seg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= '1;
         seg <= SEG_BLANK;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_alu_seg_scan_display.sv
// Directed bench for alu_seg_scan_display at WIDTH=8, DIGITS=3, SCAN_DIV=4, BLANK_LZ=1.
module tb_alu_seg_scan_display;

   localparam int WIDTH    = 8;
   localparam int DIGITS   = 3;
   localparam int SCAN_DIV = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a, b;
   logic [1:0]        op;
   logic [WIDTH:0]    result;
   logic              neg;
   logic              res_valid;
   logic [DIGITS-1:0] an;
   logic [6:0]        seg;

   int total = 0;
   int bad   = 0;

   alu_seg_scan_display #(
      .WIDTH    (WIDTH),
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .BLANK_LZ (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .result    (result),
      .neg       (neg),
      .res_valid (res_valid),
      .an        (an),
      .seg       (seg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH:0]   res;
      logic             neg;
      logic [6:0]       s2, s1, s0;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int n);
      logic [6:0] cap[DIGITS];
      bit         seen[DIGITS];
      for (int d = 0; d < DIGITS; d++) begin
         cap[d]  = 7'h55;
         seen[d] = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1; a = v.a; b = v.b; op = v.op;
      chk($sformatf("v%0d accept_ready", n), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d calc_ready", n), 32'(in_ready), 32'd0);
      chk($sformatf("v%0d calc_rv", n), 32'(res_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d rv_pulse", n), 32'(res_valid), 32'd1);
      chk($sformatf("v%0d result", n), 32'(result), 32'(v.res));
      chk($sformatf("v%0d neg", n), 32'(neg), 32'(v.neg));
      @(negedge clk);
      chk($sformatf("v%0d rv_drop", n), 32'(res_valid), 32'd0);
      for (int j = 0; j < 14; j++) begin
         case (an)
            3'b110: begin cap[0] = seg; seen[0] = 1'b1; end
            3'b101: begin cap[1] = seg; seen[1] = 1'b1; end
            3'b011: begin cap[2] = seg; seen[2] = 1'b1; end
            default: ;
         endcase
         @(negedge clk);
      end
      chk($sformatf("v%0d seen_all", n), 32'({seen[2], seen[1], seen[0]}), 32'd7);
      chk($sformatf("v%0d dig2", n), 32'(cap[2]), 32'(v.s2));
      chk($sformatf("v%0d dig1", n), 32'(cap[1]), 32'(v.s1));
      chk($sformatf("v%0d dig0", n), 32'(cap[0]), 32'(v.s0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'b00, 8'hC5, 8'h4B, 9'h110, 1'b0, 7'h79, 7'h79, 7'h40};
      vecs[1] = '{2'b01, 8'h09, 8'h34, 9'h02B, 1'b1, 7'h3F, 7'h24, 7'h03};
      vecs[2] = '{2'b10, 8'hF0, 8'h3C, 9'h030, 1'b0, 7'h7F, 7'h30, 7'h40};
      vecs[3] = '{2'b11, 8'h0F, 8'h00, 9'h00F, 1'b0, 7'h7F, 7'h7F, 7'h0E};
      vecs[4] = '{2'b01, 8'h55, 8'h55, 9'h000, 1'b0, 7'h7F, 7'h7F, 7'h40};
      vecs[5] = '{2'b00, 8'hFF, 8'hFF, 9'h1FE, 1'b0, 7'h79, 7'h0E, 7'h06};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst result", 32'(result), 32'd0);
      chk("rst neg", 32'(neg), 32'd0);
      chk("rst res_valid", 32'(res_valid), 32'd0);
      chk("rst an", 32'(an), 32'b111);
      chk("rst seg", 32'(seg), 32'h7F);

      // Scan order and dwell: each enable pattern for SCAN_DIV cycles, result 0 shows only digit 0.
      for (int c = 1; c <= 16; c++) begin
         logic [2:0] exp_an;
         logic [6:0] exp_seg;
         @(negedge clk);
         exp_an  = ~(3'b001 << (((c - 1) / SCAN_DIV) % DIGITS));
         exp_seg = (exp_an == 3'b110) ? 7'h40 : 7'h7F;
         chk($sformatf("scan an c%0d", c), 32'(an), 32'(exp_an));
         chk($sformatf("scan seg c%0d", c), 32'(seg), 32'(exp_seg));
      end

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Continuous in_valid: accepted only when in_ready, i.e. every other cycle.
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; op = 2'b00;
         a = 8'(8'h10 + k); b = 8'(k);
         chk($sformatf("hs ready k%0d", k), 32'(in_ready), 32'((k % 2) == 0));
         if (k >= 2 && (k % 2) == 0) begin
            chk($sformatf("hs rv k%0d", k), 32'(res_valid), 32'd1);
            chk($sformatf("hs res k%0d", k), 32'(result), 32'(8'h10 + 2 * (k - 2)));
         end else begin
            chk($sformatf("hs rv k%0d", k), 32'(res_valid), 32'd0);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("hs rv last", 32'(res_valid), 32'd1);
      chk("hs res last", 32'(result), 32'h1C);

      // Reset landing in CALC discards the operation.
      repeat (2) @(negedge clk);
      in_valid = 1'b1; a = 8'hFF; b = 8'h01; op = 2'b00;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid ready calc", 32'(in_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("mid async result", 32'(result), 32'd0);
      chk("mid async ready", 32'(in_ready), 32'd1);
      chk("mid async an", 32'(an), 32'b111);
      chk("mid async seg", 32'(seg), 32'h7F);
      @(negedge clk);
      chk("mid rv held", 32'(res_valid), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("mid rv after k%0d", k), 32'(res_valid), 32'd0);
         chk($sformatf("mid res after k%0d", k), 32'(result), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
